flash_loader: RTL and testbench
===============================

FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 SHALL have parameter FLASH_AW, default 23, flash word-address width.
REQ-002 SHALL have parameter DW, default 16, data width.
REQ-003 SHALL have parameter MEM_AW, default 18, destination address width.
REQ-004 SHALL have parameter WORDS, default 512, words copied per run (range 1..2^MEM_AW).
REQ-005 SHALL have parameter WAIT, default 4, flash read-access wait cycles (range 1..15).
REQ-006 SHALL have parameters SRC_BASE, default 0, and DST_BASE, default 0: start addresses.
REQ-007 SHALL have parameter AUTOSTART, default 1: if 1, a copy starts after reset without a start pulse.
REQ-008 SHALL have ports: clk  input  1  system clock, rising edge; rst  input  1  asynchronous, active-low reset.
REQ-009 SHALL have ports: start  input  1  one-cycle copy request; busy  output  1  copy in progress; done  output  1  sticky, copy complete.
REQ-010 SHALL have ports: flash_addr  output  FLASH_AW  word address; flash_data  inout  DW  data bus.
REQ-011 SHALL have ports: flash_byte, flash_vpen, flash_ce, flash_oe, flash_we, flash_rp  output  1 each; ce/oe/we/rp are active-low.
REQ-012 SHALL have ports: mem_addr  output  MEM_AW; mem_data  output  DW; mem_we  output  1  write request; mem_ready  input  1  write accepted.

Function
REQ-013 SHALL never drive flash_data: it is high-impedance at all times.
REQ-014 SHALL hold flash_byte=1 (word mode), flash_vpen=0 (programming disabled) and flash_we=1 at all times.
REQ-015 SHALL use states IDLE, SETUP, WAIT, LATCH, WRITE, NEXT, DONE.
REQ-016 IDLE: ce=1, oe=1, busy=0; goes to SETUP on start=1, or on the first cycle after reset when AUTOSTART=1.
REQ-017 SETUP: drive flash_addr=SRC_BASE+count, ce=0, oe=0, and load wait counter with WAIT-1; next state WAIT.
REQ-018 WAIT: hold ce=0 and oe=0, decrement counter; go to LATCH when counter reaches 0 (WAIT cycles in WAIT state).
REQ-019 LATCH: register flash_data into mem_data, ce=1, oe=1; next state WRITE.
REQ-020 WRITE: mem_we=1, mem_addr=DST_BASE+count, mem_data stable; stay until mem_ready=1 is sampled, then go to NEXT with mem_we=0.
REQ-021 NEXT: if count==WORDS-1 go to DONE, else count+1 and go to SETUP.
REQ-022 Minimum per-word latency SHALL be WAIT+4 cycles (mem_ready tied 1).
REQ-023 DONE: done=1, busy=0; done stays 1 until reset or a new start, which clears done and enters SETUP with count=0.
REQ-024 busy SHALL be 1 in every state except IDLE and DONE; start while busy SHALL be ignored.
REQ-025 Address arithmetic SHALL wrap modulo 2^FLASH_AW (flash) and 2^MEM_AW (destination); no error is flagged.
REQ-026 mem_we SHALL be asserted only in WRITE; exactly WORDS write handshakes per run.
REQ-027 count SHALL be wide enough for WORDS-1 (clog2, minimum 1 bit).

Reset
REQ-028 On rst=0, immediately and asynchronously: state=IDLE, count=0, flash_addr=0, flash_ce=1, flash_oe=1, flash_rp=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0.
REQ-029 flash_rp SHALL go to 1 on the first rising clk edge after rst returns high.
REQ-030 Reset mid-copy SHALL abort without a further mem_we; the run then restarts from count=0 per REQ-016.

Verification
REQ-031 AUTOSTART=1, WORDS=4, WAIT=2, flash model returns addr^16'hA5A5, mem_ready=1 -> writes 0..3 get A5A5,A5A4,A5A7,A5A6; done=1 at cycle 1+4*6.
REQ-032 mem_ready held 0 for 5 cycles on word 1 -> mem_we stays 1 with stable addr/data for 6 cycles, then the run continues; no word is lost or duplicated.
REQ-033 SRC_BASE=23'h7FFFFE, WORDS=4 -> flash_addr sequence 7FFFFE, 7FFFFF, 000000, 000001.
REQ-034 rst pulsed low during WAIT of word 2 -> ce/oe go to 1 and mem_we to 0 without waiting for a clock edge; the restart re-copies word 0.
REQ-035 AUTOSTART=0 -> no flash access until start; a start during busy is ignored; a start in DONE clears done and recopies.
REQ-036 For the whole run: flash_we=1, flash_vpen=0, flash_byte=1, and flash_data is never driven.

Source files
------------

// File: rtl/flash_loader.sv
// flash_loader: copies WORDS words from a parallel NOR flash (read-only) into a destination memory.
// Ports: clk, rst (async active-low); start/busy/done control; flash_addr/flash_data plus
// flash_byte/vpen/ce/oe/we/rp flash pins (ce/oe/we/rp active-low); mem_addr/mem_data/mem_we/mem_ready
// destination write port (mem_we held until mem_ready is sampled high).
module flash_loader #(
    parameter int                  FLASH_AW  = 23,
    parameter int                  DW        = 16,
    parameter int                  MEM_AW    = 18,
    parameter int                  WORDS     = 512,
    parameter int                  WAIT      = 4,
    parameter logic [FLASH_AW-1:0] SRC_BASE  = '0,
    parameter logic [MEM_AW-1:0]   DST_BASE  = '0,
    parameter bit                  AUTOSTART = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [FLASH_AW-1:0] flash_addr,
    inout  wire  [DW-1:0]       flash_data,
    output logic                flash_byte,
    output logic                flash_vpen,
    output logic                flash_ce,
    output logic                flash_oe,
    output logic                flash_we,
    output logic                flash_rp,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DW-1:0]       mem_data,
    output logic                mem_we,
    input  logic                mem_ready
);
    localparam int            CW   = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_LATCH, S_WRITE, S_NEXT, S_DONE} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] count;
    logic [3:0]    wcnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            count    <= '0;
            wcnt     <= '0;
            mem_data <= '0;
            flash_rp <= 1'b0;
        end else begin
            state    <= state_nx;
            flash_rp <= 1'b1;
            if (state == S_SETUP) wcnt <= 4'(WAIT - 1);
            else if (state == S_WAIT) wcnt <= wcnt - 4'd1;
            if (state == S_LATCH) mem_data <= flash_data;
            if (state == S_IDLE || state == S_DONE) count <= '0;
            else if (state == S_NEXT && count != LAST) count <= count + 1'b1;
        end
    end
    // flash_rp is still low only on the first clock after reset, which doubles as the autostart trigger
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = (start || (AUTOSTART && !flash_rp)) ? S_SETUP : S_IDLE;
            S_SETUP: state_nx = S_WAIT;
            S_WAIT:  state_nx = wcnt == 4'd0 ? S_LATCH : S_WAIT;
            S_LATCH: state_nx = S_WRITE;
            S_WRITE: state_nx = mem_ready ? S_NEXT : S_WRITE;
            S_NEXT:  state_nx = count == LAST ? S_DONE : S_SETUP;
            S_DONE:  state_nx = start ? S_SETUP : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end
    // control pins decode straight from the async-reset state so reset takes effect without a clock
    assign busy       = state != S_IDLE && state != S_DONE;
    assign done       = state == S_DONE;
    assign flash_ce   = !(state == S_SETUP || state == S_WAIT);
    assign flash_oe   = flash_ce;
    assign mem_we     = state == S_WRITE;
    assign flash_addr = busy ? SRC_BASE + FLASH_AW'(count) : '0;
    assign mem_addr   = busy ? DST_BASE + MEM_AW'(count) : '0;
    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b0;
    assign flash_we   = 1'b1;
endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: scoreboard bench for flash_loader, one autostart instance and one start-driven instance.
module tb_flash_loader;
    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
        int          c;
    } ent_t;

    logic clk = 1'b0, rst0 = 1'b0, rst1 = 1'b0, start0 = 1'b0, start1 = 1'b0, hold0 = 1'b0;
    logic busy0, done0, byte0, vpen0, ce0, oe0, we0, rp0, mwe0, rdy0;
    logic busy1, done1, byte1, vpen1, ce1, oe1, we1, rp1, mwe1, rdy1;
    logic [22:0] fa0, fa1;
    logic [17:0] ma0, ma1;
    logic [15:0] md0, md1;
    wire  [15:0] fd0, fd1;
    int cmp = 0, err = 0;
    ent_t q0[$], q1[$];
    logic [22:0] fq1[$];
    int wc0 = 0, wc1 = 0;
    logic [33:0] first0 = '0;
    logic pce1 = 1'b1;

    always #5 clk = ~clk;

    // flash model: read data is the word address xor A5A5, held on the bus
    assign fd0  = fa0[15:0] ^ 16'hA5A5;
    assign fd1  = fa1[15:0] ^ 16'hA5A5;
    assign rdy0 = !(hold0 && mwe0 && ma0 == 18'd1);
    assign rdy1 = 1'b1;

    flash_loader #(.WORDS(4), .WAIT(2)) u0 (
        .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0),
        .flash_addr(fa0), .flash_data(fd0), .flash_byte(byte0), .flash_vpen(vpen0),
        .flash_ce(ce0), .flash_oe(oe0), .flash_we(we0), .flash_rp(rp0),
        .mem_addr(ma0), .mem_data(md0), .mem_we(mwe0), .mem_ready(rdy0));

    flash_loader #(.WORDS(4), .WAIT(2), .AUTOSTART(1'b0), .SRC_BASE(23'h7FFFFE), .DST_BASE(18'h3FFFE)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
        .flash_addr(fa1), .flash_data(fd1), .flash_byte(byte1), .flash_vpen(vpen1),
        .flash_ce(ce1), .flash_oe(oe1), .flash_we(we1), .flash_rp(rp1),
        .mem_addr(ma1), .mem_data(md1), .mem_we(mwe1), .mem_ready(rdy1));

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        cmp++;
        if (a !== e) begin
            err++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic push0(input logic [17:0] a, input logic [15:0] d, input int c);
        q0.push_back('{a, d, c});
    endtask

    task automatic push1(input logic [17:0] a, input logic [15:0] d);
        q1.push_back('{a, d, 1});
    endtask

    task automatic wait_done0(output int n);
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done0_reached", done0, 1);
    endtask

    task automatic wait_done1(output int n);
        n = 0;
        while (!done1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done1_reached", done1, 1);
    endtask

    task automatic load1;
        fq1.push_back(23'h7FFFFE);
        fq1.push_back(23'h7FFFFF);
        fq1.push_back(23'h000000);
        fq1.push_back(23'h000001);
        push1(18'h3FFFE, 16'h5A5B);
        push1(18'h3FFFF, 16'h5A5A);
        push1(18'h00000, 16'hA5A5);
        push1(18'h00001, 16'hA5A4);
    endtask

    // monitor u0: every write handshake is popped and compared, including its mem_we length
    always @(negedge clk) begin
        chk("static_pins0", {byte0, vpen0, we0}, 3'b101);
        if (mwe0) begin
            if (wc0 == 0) first0 <= {ma0, md0};
            else chk("we_stable0", {ma0, md0}, first0);
            if (rdy0) begin
                chk("wr_expected0", q0.size() > 0, 1);
                if (q0.size() > 0) begin
                    chk("wr_addr0", ma0, q0[0].a);
                    chk("wr_data0", md0, q0[0].d);
                    chk("wr_cycles0", wc0 + 1, q0[0].c);
                    void'(q0.pop_front());
                end
            end
        end
        wc0 <= mwe0 && !rdy0 ? wc0 + 1 : 0;
    end

    // monitor u1: writes plus the flash address at each ce falling edge
    always @(negedge clk) begin
        chk("static_pins1", {byte1, vpen1, we1}, 3'b101);
        if (!ce1 && pce1) begin
            chk("flash_expected1", fq1.size() > 0, 1);
            if (fq1.size() > 0) begin
                chk("flash_addr1", fa1, fq1[0]);
                void'(fq1.pop_front());
            end
        end
        pce1 <= ce1;
        if (mwe1 && rdy1) begin
            chk("wr_expected1", q1.size() > 0, 1);
            if (q1.size() > 0) begin
                chk("wr_addr1", ma1, q1[0].a);
                chk("wr_data1", md1, q1[0].d);
                chk("wr_cycles1", wc1 + 1, q1[0].c);
                void'(q1.pop_front());
            end
        end
        wc1 <= mwe1 && !rdy1 ? wc1 + 1 : 0;
    end

    initial begin
        int n;
        #2;
        chk("rst_state0", {busy0, done0, ce0, oe0, rp0, mwe0, fa0, ma0, md0},
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 23'd0, 18'd0, 16'd0});
        chk("rst_state1", {busy1, done1, ce1, oe1, rp1, mwe1}, 6'b001100);
        for (int i = 0; i < 4; i++) push0(18'(i), 16'(i) ^ 16'hA5A5, 1);
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);
        chk("rp_after_edge0", rp0, 1);
        chk("autostart0", {ce0, oe0, busy0}, 3'b001);
        chk("idle1", {ce1, oe1, busy1, done1}, 4'b1100);
        wait_done0(n);
        chk("done_cycle0", n + 1, 25);
        repeat (3) @(negedge clk);
        chk("done_sticky0", {done0, busy0, mwe0}, 3'b100);
        chk("still_idle1", {ce1, oe1, busy1, done1}, 4'b1100);

        hold0 = 1'b1;
        push0(18'd0, 16'hA5A5, 1);
        push0(18'd1, 16'hA5A4, 6);
        push0(18'd2, 16'hA5A7, 1);
        push0(18'd3, 16'hA5A6, 1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("done_clear0", {done0, busy0}, 2'b01);
        n = 0;
        while (!(mwe0 && ma0 == 18'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached0", mwe0 && ma0 == 18'd1, 1);
        repeat (5) @(posedge clk);
        #1 hold0 = 1'b0;
        wait_done0(n);

        push0(18'd0, 16'hA5A5, 1);
        push0(18'd1, 16'hA5A4, 1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!(!ce0 && fa0 == 23'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_word2", {ce0, fa0}, {1'b0, 23'd2});
        @(negedge clk);
        chk("in_wait0", {ce0, oe0, mwe0, busy0}, 4'b0001);
        #2 rst0 = 1'b0;
        #1 chk("async_rst0", {ce0, oe0, mwe0, busy0, done0, rp0}, 6'b110000);
        repeat (2) @(negedge clk);
        chk("held_rst0", {ce0, oe0, mwe0, busy0, fa0}, {4'b1100, 23'd0});
        chk("no_extra_wr0", q0.size(), 0);
        for (int i = 0; i < 4; i++) push0(18'(i), 16'(i) ^ 16'hA5A5, 1);
        rst0 = 1'b1;
        wait_done0(n);
        chk("restart_cycle0", n, 25);

        chk("no_start_idle1", {ce1, busy1, done1}, 3'b100);
        load1();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(n);
        chk("done_cycle1", n, 21);
        repeat (2) @(negedge clk);
        chk("done_sticky1", {done1, busy1}, 2'b10);
        load1();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("done_clear1", {done1, busy1}, 2'b01);
        wait_done1(n);
        chk("redo_cycle1", n, 24);

        repeat (2) @(negedge clk);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("fq1_empty", fq1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
